// File: rtl/smartbing_pkg.sv
// Shared types and default constants for the SmartBing tank controller.
package smartbing_pkg;

    // Channel state codes; these values appear directly on state_o.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_FULL  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    localparam int DEF_DB_CYC  = 4;
    localparam int DEF_RUN_W   = 8;
    localparam int DEF_MAX_RUN = 200;

endpackage

// File: rtl/smartbing_tank_ch.sv
// One tank channel: two sensor debouncers, the pump FSM and the dry-run timer.
module smartbing_tank_ch
    import smartbing_pkg::*;
#(
    parameter int DB_CYC  = DEF_DB_CYC,
    parameter int RUN_W   = DEF_RUN_W,
    parameter int MAX_RUN = DEF_MAX_RUN
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   auto_mode,
    input  logic   start,
    input  logic   clr,
    input  logic   lvl_hi,
    input  logic   lvl_lo,
    output logic   motor,
    output logic   full,
    output logic   low,
    output logic   alarm,
    output state_t state
);

    localparam int               CNT_W    = (DB_CYC > 2) ? $clog2(DB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_RUN - 1);

    // Run timer increment that holds at the timeout value instead of wrapping.
    function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] v);
        return (v == RUN_LAST) ? v : v + 1'b1;
    endfunction

    // Index 0 is the high sensor, index 1 the low sensor.
    logic [1:0]       raw;
    logic [1:0]       db;
    logic [CNT_W-1:0] cnt [2];

    state_t           state_nxt;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_nxt;
    logic             motor_q;
    logic             alarm_q;

    logic hi_db;
    logic is_low;
    logic sensor_bad;

    assign raw        = {lvl_lo, lvl_hi};
    assign hi_db      = db[0];
    assign is_low     = ~db[1];
    // Water at the top but not above the bottom cannot be real.
    assign sensor_bad = hi_db & is_low;

    // Debounce: a raw value must differ from the accepted one for DB_CYC samples in a row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db     <= 2'b10;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= raw[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Next state and timer: sensor fault beats fault exit, which beats enable, which beats normal flow.
    always_comb begin
        state_nxt = state;
        run_nxt   = '0;
        if (sensor_bad) begin
            state_nxt = ST_FAULT;
        end else if (state == ST_FAULT) begin
            // start is deliberately ignored here; only clr leaves FAULT.
            state_nxt = clr ? ST_IDLE : ST_FAULT;
        end else if (!en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!hi_db && (start || is_low)) state_nxt = ST_FILL;
                end
                ST_FILL: begin
                    if (hi_db)                 state_nxt = ST_FULL;
                    else if (run == RUN_LAST)  state_nxt = ST_FAULT;
                end
                ST_FULL: begin
                    if (is_low) state_nxt = auto_mode ? ST_FILL : ST_IDLE;
                end
                default: state_nxt = state;
            endcase
        end
        // Timer is frozen in FAULT, counts while FILL persists, and is zero everywhere else.
        if (state_nxt == ST_FAULT) begin
            run_nxt = run;
        end else if ((state == ST_FILL) && (state_nxt == ST_FILL)) begin
            run_nxt = run_sat_inc(run);
        end
    end

    // State, timer and registered outputs all update on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            run     <= '0;
            motor_q <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            run     <= run_nxt;
            motor_q <= (state_nxt == ST_FILL);
            alarm_q <= (state_nxt == ST_FAULT);
        end
    end

    assign motor = motor_q;
    assign alarm = alarm_q;
    assign full  = hi_db;
    assign low   = is_low;

endmodule

// File: rtl/smartbing_tank_ctrl.sv
// Multi-channel pump/level controller: CH independent tank channels plus a shared alarm.
module smartbing_tank_ctrl
    import smartbing_pkg::*;
#(
    parameter int CH      = 2,
    parameter int DB_CYC  = DEF_DB_CYC,
    parameter int RUN_W   = DEF_RUN_W,
    parameter int MAX_RUN = DEF_MAX_RUN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            auto_mode,
    input  logic [CH-1:0]   start,
    input  logic [CH-1:0]   clr,
    input  logic [CH-1:0]   lvl_hi,
    input  logic [CH-1:0]   lvl_lo,
    output logic [CH-1:0]   motor,
    output logic [CH-1:0]   full,
    output logic [CH-1:0]   low,
    output logic [CH-1:0]   alarm,
    output logic            any_alarm,
    output logic [2*CH-1:0] state_o
);

    state_t ch_state [CH];

    for (genvar g = 0; g < CH; g++) begin : g_ch
        smartbing_tank_ch #(
            .DB_CYC  (DB_CYC),
            .RUN_W   (RUN_W),
            .MAX_RUN (MAX_RUN)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .auto_mode (auto_mode),
            .start     (start[g]),
            .clr       (clr[g]),
            .lvl_hi    (lvl_hi[g]),
            .lvl_lo    (lvl_lo[g]),
            .motor     (motor[g]),
            .full      (full[g]),
            .low       (low[g]),
            .alarm     (alarm[g]),
            .state     (ch_state[g])
        );
        assign state_o[2*g +: 2] = ch_state[g];
    end

    assign any_alarm = |alarm;

endmodule

// File: tb/tb_smartbing_tank_ctrl.sv
// Directed bench for smartbing_tank_ctrl (CH=2, DB_CYC=4, MAX_RUN=16).
module tb_smartbing_tank_ctrl;

    localparam int CH = 2;
    localparam logic [1:0] S_IDLE = 2'b00, S_FILL = 2'b01, S_FULL = 2'b10, S_FAULT = 2'b11;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            auto_mode;
    logic [CH-1:0]   start;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   lvl_hi;
    logic [CH-1:0]   lvl_lo;
    logic [CH-1:0]   motor;
    logic [CH-1:0]   full;
    logic [CH-1:0]   low;
    logic [CH-1:0]   alarm;
    logic            any_alarm;
    logic [2*CH-1:0] state_o;

    smartbing_tank_ctrl #(
        .CH      (CH),
        .DB_CYC  (4),
        .RUN_W   (8),
        .MAX_RUN (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .auto_mode (auto_mode),
        .start     (start),
        .clr       (clr),
        .lvl_hi    (lvl_hi),
        .lvl_lo    (lvl_lo),
        .motor     (motor),
        .full      (full),
        .low       (low),
        .alarm     (alarm),
        .any_alarm (any_alarm),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected snapshot {state, alarm, low, full, motor}; ch == CH means any_alarm in bit 0.
    typedef struct {
        int         due;
        int         ch;
        logic [5:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ch(input int dly, input int ch, input string nm, input logic [1:0] st,
                             input logic m, input logic f, input logic l, input logic a);
        exp_t e;
        e.due  = cyc + dly;
        e.ch   = ch;
        e.val  = {st, a, l, f, m};
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic expect_any(input int dly, input string nm, input logic v);
        exp_t e;
        e.due  = cyc + dly;
        e.ch   = CH;
        e.val  = {5'b0, v};
        e.name = nm;
        sb.push_back(e);
    endtask

    function automatic logic [5:0] observe(input int ch);
        if (ch == CH) return {5'b0, any_alarm};
        return {state_o[2*ch +: 2], alarm[ch], low[ch], full[ch], motor[ch]};
    endfunction

    // Monitor: on each falling edge compare every expectation due this cycle.
    initial begin
        logic [5:0] act;
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due <= cyc) begin
                    act = observe(sb[i].ch);
                    checks++;
                    if ((sb[i].due < cyc) || (act !== sb[i].val)) begin
                        errors++;
                        $display("FAIL %s ch%0d cycle %0d: got {st,alarm,low,full,motor}=%b, expected %b",
                                 sb[i].name, sb[i].ch, cyc, act, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        // Reset with random raw inputs
        rst_n     = 1'b0;
        en        = 1'($urandom);
        auto_mode = 1'($urandom);
        start     = 2'($urandom);
        clr       = 2'($urandom);
        lvl_hi    = 2'($urandom);
        lvl_lo    = 2'($urandom);
        tick(2);
        checks++;
        if ((state_o !== 4'b0000) || (motor !== 2'b00) || (alarm !== 2'b00) || (any_alarm !== 1'b0)) begin
            errors++;
            $display("FAIL direct reset: state_o=%b motor=%b alarm=%b any_alarm=%b", state_o, motor, alarm, any_alarm);
        end
        expect_ch(0, 0, "rst_ch0", S_IDLE, 0, 0, 0, 0);
        expect_ch(0, 1, "rst_ch1", S_IDLE, 0, 0, 0, 0);
        expect_any(0, "rst_any", 1'b0);
        rst_n = 1'b1; en = 1'b1; auto_mode = 1'b0; start = '0; clr = '0;
        lvl_hi = 2'b00; lvl_lo = 2'b11;
        expect_ch(1, 0, "idle_ch0", S_IDLE, 0, 0, 0, 0);
        expect_ch(1, 1, "idle_ch1", S_IDLE, 0, 0, 0, 0);
        tick(1);

        // Normal fill on ch0
        start[0] = 1'b1;
        expect_ch(1, 0, "fill_start", S_FILL, 1, 0, 0, 0);
        tick(1);
        start[0] = 1'b0; lvl_hi[0] = 1'b1;
        expect_ch(3, 0, "fill_pre_full", S_FILL, 1, 0, 0, 0);
        expect_ch(4, 0, "full_seen", S_FILL, 1, 1, 0, 0);
        expect_ch(5, 0, "full_state", S_FULL, 0, 1, 0, 0);
        expect_ch(5, 1, "ch1_idle", S_IDLE, 0, 0, 0, 0);
        tick(5);

        // Drain in FULL, auto refill
        lvl_hi[0] = 1'b0;
        expect_ch(4, 0, "full_drop", S_FULL, 0, 0, 0, 0);
        tick(5);
        lvl_lo[0] = 1'b0; auto_mode = 1'b1;
        expect_ch(4, 0, "low_seen", S_FULL, 0, 0, 1, 0);
        expect_ch(5, 0, "auto_refill", S_FILL, 1, 0, 1, 0);
        tick(5);
        lvl_hi[0] = 1'b1; lvl_lo[0] = 1'b1;
        expect_ch(4, 0, "refull_seen", S_FILL, 1, 1, 0, 0);
        expect_ch(5, 0, "refull_state", S_FULL, 0, 1, 0, 0);
        tick(5);

        // Manual mode: FULL on low returns to IDLE (which then refills on low)
        auto_mode = 1'b0; lvl_hi[0] = 1'b0; lvl_lo[0] = 1'b0;
        expect_ch(5, 0, "manual_idle", S_IDLE, 0, 0, 1, 0);
        expect_ch(6, 0, "idle_low_fill", S_FILL, 1, 0, 1, 0);
        tick(6);
        en = 1'b0;
        expect_ch(1, 0, "en_off", S_IDLE, 0, 0, 1, 0);
        tick(1);
        lvl_lo[0] = 1'b1;
        tick(5);
        en = 1'b1;
        expect_ch(1, 0, "idle_settled", S_IDLE, 0, 0, 0, 0);
        tick(1);

        // Glitch rejection during FILL, then dry-run timeout
        start[0] = 1'b1;
        expect_ch(1, 0, "glitch_fill", S_FILL, 1, 0, 0, 0);
        tick(1);
        start[0] = 1'b0; lvl_hi[0] = 1'b1;
        tick(3);
        lvl_hi[0] = 1'b0;
        expect_ch(2, 0, "glitch_reject", S_FILL, 1, 0, 0, 0);
        expect_ch(4, 0, "glitch_reject2", S_FILL, 1, 0, 0, 0);
        expect_ch(12, 0, "pre_timeout", S_FILL, 1, 0, 0, 0);
        expect_any(12, "pre_timeout_any", 1'b0);
        expect_ch(13, 0, "timeout", S_FAULT, 0, 0, 0, 1);
        expect_any(13, "timeout_any", 1'b1);
        tick(13);
        checks++;
        if ((state_o[1:0] !== S_FAULT) || (motor[0] !== 1'b0) || (any_alarm !== 1'b1)) begin
            errors++;
            $display("FAIL direct timeout: state_o=%b motor=%b any_alarm=%b", state_o, motor, any_alarm);
        end
        clr[0] = 1'b1; start[0] = 1'b1;
        expect_ch(1, 0, "clr_exit", S_IDLE, 0, 0, 0, 0);
        expect_any(1, "clr_exit_any", 1'b0);
        tick(1);
        clr[0] = 1'b0; start[0] = 1'b0;
        expect_ch(1, 0, "start_ignored", S_IDLE, 0, 0, 0, 0);
        tick(1);

        // Sensor fault on ch1
        lvl_hi[1] = 1'b1; lvl_lo[1] = 1'b0;
        expect_ch(4, 1, "sf_pre", S_IDLE, 0, 1, 1, 0);
        expect_ch(5, 1, "sens_fault", S_FAULT, 0, 1, 1, 1);
        expect_any(5, "sens_fault_any", 1'b1);
        expect_ch(5, 0, "ch0_indep", S_IDLE, 0, 0, 0, 0);
        tick(5);
        checks++;
        if (alarm[1] !== 1'b1) begin
            errors++;
            $display("FAIL direct sensor fault: alarm=%b", alarm);
        end
        clr[1] = 1'b1; en = 1'b0;
        expect_ch(1, 1, "clr_inconsistent", S_FAULT, 0, 1, 1, 1);
        tick(1);
        clr[1] = 1'b0; en = 1'b1; lvl_hi[1] = 1'b0; lvl_lo[1] = 1'b1;
        expect_ch(4, 1, "fault_held", S_FAULT, 0, 0, 0, 1);
        tick(4);
        clr[1] = 1'b1;
        expect_ch(1, 1, "fault_cleared", S_IDLE, 0, 0, 0, 0);
        expect_any(1, "fault_cleared_any", 1'b0);
        tick(1);
        checks++;
        if (alarm[1] !== 1'b0) begin
            errors++;
            $display("FAIL direct fault clear: alarm=%b", alarm);
        end
        clr[1] = 1'b0;

        // Reset in the middle of FILL
        start[0] = 1'b1;
        expect_ch(1, 0, "rst_fill", S_FILL, 1, 0, 0, 0);
        tick(1);
        start[0] = 1'b0; rst_n = 1'b0;
        expect_ch(1, 0, "rst_mid_fill", S_IDLE, 0, 0, 0, 0);
        tick(1);
        checks++;
        if (motor !== 2'b00) begin
            errors++;
            $display("FAIL direct reset mid-fill: motor=%b", motor);
        end
        rst_n = 1'b1;
        expect_ch(1, 0, "post_rst", S_IDLE, 0, 0, 0, 0);
        expect_any(1, "post_rst_any", 1'b0);
        tick(2);

        for (int k = 0; (k < 50) && (sb.size() != 0); k++) @(posedge clk);
        while (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s ch%0d: never compared (due %0d, now %0d)", sb[0].name, sb[0].ch, sb[0].due, cyc);
            void'(sb.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
